batrider_snd_mailbox: RTL and testbench
=======================================

Name: batrider_snd_mailbox

Overview:
- 68000-side mailbox feeding the Z80 sound subsystem.
- Decodes main-CPU accesses to the sound-latch window and holds the two command latches (SOUNDLATCH, SOUNDLATCH2).
- Raises the command strobe CS that sets the Z80 NMI and the 68k wait flip-flop, stretches 68k DTACK while the sound side holds WAIT, and returns SOUNDLATCH3/4 readback.
- Converts the Z80 SNDIRQ into a latched, acknowledgeable 68k interrupt request.

Parameters:
- STROBE_LEN, 4: CLK96 cycles CS is held high per command strobe.
- WAIT_SETTLE, 2: cycles after CS falls before WAIT is sampled.
- WAIT_TIMEOUT, 4096: maximum cycles DTACK is stretched waiting on WAIT; 12-bit counter.

Ports:
- CLK96  in  1  system clock, all logic on rising edge.
- RESET96_N  in  1  asynchronous, active-low reset.
- SEL  in  1  window select (sync to CLK96), high for the whole 68k bus cycle.
- RWn  in  1  1 = read, 0 = write.
- LDSn  in  1  lower data strobe, active low; accesses without it are ignored and get DTACK only.
- ADDR  in  2  word offset A[2:1] within window.
- M68K_DIN  in  8  write data, low byte.
- M68K_DOUT  out  8  read data.
- DTACKn  out  1  data acknowledge, active low.
- SOUNDLATCH  out  8  command latch 0 to Z80.
- SOUNDLATCH2  out  8  command latch 1 to Z80.
- CS  out  1  command strobe to sound block; its rising edge triggers NMI/WAIT there.
- WAIT  in  1  sound-side busy flag; cleared by Z80 NMI clear.
- SOUNDLATCH3  in  8  Z80 reply latch 0.
- SOUNDLATCH4  in  8  Z80 reply latch 1.
- SNDIRQ  in  1  Z80-side interrupt request level.
- IACK  in  1  one-cycle 68k interrupt acknowledge for this level.
- IRQn  out  1  level interrupt to 68k, active low.

Behaviour:
- Reset values (async, RESET96_N low):
  - SOUNDLATCH = 0x00, SOUNDLATCH2 = 0x00
  - CS = 0, DTACKn = 1, IRQn = 1, M68K_DOUT = 0xFF
  - FSM in IDLE, counters 0, irq_pend = 0, SNDIRQ edge register = 0.
- Register map (ADDR):
  - 0: write SOUNDLATCH; read SOUNDLATCH3.
  - 1: write SOUNDLATCH2; read SOUNDLATCH4.
  - 2: write = command strobe, data ignored; read 0xFF.
  - 3: write = clear irq_pend; read {7'b0, irq_pend}.
- FSM states:
  - IDLE: on SEL rising edge, capture ADDR/RWn/data.
    - Read: goes to ACK.
    - Write to 0/1/3: updates the register the same cycle, goes to ACK.
    - Write to 2: goes to STROBE.
  - STROBE: CS = 1 for exactly STROBE_LEN cycles, then SETTLE.
  - SETTLE: CS = 0 for WAIT_SETTLE cycles, then HOLD.
  - HOLD: DTACKn stays 1 while WAIT = 1 and timeout counter < WAIT_TIMEOUT.
    - On WAIT = 0 or timeout, go to ACK.
    - Timeout also sets sticky flag tmo (debug only, not a port).
  - ACK: DTACKn = 0 and M68K_DOUT valid; hold until SEL falls, then IDLE with DTACKn = 1 the next cycle.
- Latency:
  - Read/plain write: DTACKn low 1 cycle after the SEL edge; M68K_DOUT registered the same cycle.
  - Strobe: DTACKn low no earlier than STROBE_LEN + WAIT_SETTLE + 1 cycles after the edge.
- SEL dropping mid-STROBE/SETTLE/HOLD (bus error or reset of the 68k side):
  - Finish the CS pulse at its full length, skip HOLD, return to IDLE.
  - Never truncate CS.
- A new SEL edge while not in IDLE is impossible by protocol; it is ignored.
- IRQ:
  - Rising edge of SNDIRQ (registered one cycle) sets irq_pend; IRQn = ~irq_pend.
  - IACK or a write to ADDR 3 clears it.
  - Set and clear in the same cycle: set wins.
- Reads of SOUNDLATCH3/4 sample the input when entering ACK; there is no side effect on the Z80 side.

Decomposition:
- Shared package batrider_snd_pkg:
  - register offset constants (REG_LATCH0..REG_CTRL);
  - FSM state enum (IDLE, STROBE, SETTLE, HOLD, ACK);
  - default parameter constants.
- One natural sub-module: batrider_edge_det (registered rising-edge detector with async active-low reset), used for SEL and SNDIRQ.

Test Plan:
- Reset mid-strobe: assert RESET96_N low during STROBE -> CS = 0, DTACKn = 1, latches 0x00 immediately (async); after release FSM is in IDLE.
- Write 0x5A to ADDR 0, then 0xA5 to ADDR 1 -> SOUNDLATCH = 0x5A, SOUNDLATCH2 = 0xA5; DTACKn low 1 cycle after each SEL edge; CS stays 0.
- Strobe write to ADDR 2, WAIT rises 1 cycle after CS, is released 50 cycles later -> CS high exactly 4 cycles; DTACKn low 1 cycle after WAIT falls.
- Strobe with WAIT stuck high -> DTACKn low after 4 + 2 + 4096 cycles; tmo set; next read of ADDR 0 completes normally.
- SOUNDLATCH3 = 0x3C, read ADDR 0 -> M68K_DOUT = 0x3C with DTACKn low; read ADDR 2 -> 0xFF.
- SNDIRQ 0->1 -> IRQn low 2 cycles later; IACK pulse coinciding with a second SNDIRQ edge -> IRQn stays low; write ADDR 3 -> IRQn high; read ADDR 3 -> 0x00.

Source files
------------

// File: rtl/batrider_snd_pkg.sv
// Shared constants for the 68000-side sound mailbox.
// Holds register offsets, FSM state encodings and default timing values.
package batrider_snd_pkg;

  localparam int STROBE_LEN_DEF   = 4;
  localparam int WAIT_SETTLE_DEF  = 2;
  localparam int WAIT_TIMEOUT_DEF = 4096;

  localparam logic [1:0] REG_LATCH0 = 2'd0;
  localparam logic [1:0] REG_LATCH1 = 2'd1;
  localparam logic [1:0] REG_STROBE = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  typedef logic [2:0] snd_state_t;

  localparam snd_state_t ST_IDLE   = 3'd0;
  localparam snd_state_t ST_STROBE = 3'd1;
  localparam snd_state_t ST_SETTLE = 3'd2;
  localparam snd_state_t ST_HOLD   = 3'd3;
  localparam snd_state_t ST_ACK    = 3'd4;

endpackage

// File: rtl/batrider_snd_mailbox_edge_det.sv
// Rising-edge detector; REG_OUT selects a combinational or a registered pulse.
// The SEL path uses the combinational form, SNDIRQ the registered one.
module batrider_edge_det #(
  parameter bit REG_OUT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_reg <= 1'b0;
    end else begin
      d_reg <= d;
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      logic rise_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rise_reg <= 1'b0;
        end else begin
          rise_reg <= d & ~d_reg;
        end
      end
      assign rise = rise_reg;
    end else begin : g_comb
      assign rise = d & ~d_reg;
    end
  endgenerate

endmodule

// File: rtl/batrider_snd_mailbox.sv
// 68000-side sound mailbox: command latches, CS strobe with WAIT-stretched DTACK,
// Z80 reply readback and a latched, acknowledgeable sound interrupt.
module batrider_snd_mailbox
  import batrider_snd_pkg::*;
#(
  parameter int STROBE_LEN   = STROBE_LEN_DEF,
  parameter int WAIT_SETTLE  = WAIT_SETTLE_DEF,
  parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
  input  logic       CLK96,
  input  logic       RESET96_N,
  input  logic       SEL,
  input  logic       RWn,
  input  logic       LDSn,
  input  logic [1:0] ADDR,
  input  logic [7:0] M68K_DIN,
  output logic [7:0] M68K_DOUT,
  output logic       DTACKn,
  output logic [7:0] SOUNDLATCH,
  output logic [7:0] SOUNDLATCH2,
  output logic       CS,
  input  logic       WAIT,
  input  logic [7:0] SOUNDLATCH3,
  input  logic [7:0] SOUNDLATCH4,
  input  logic       SNDIRQ,
  input  logic       IACK,
  output logic       IRQn
);

  localparam logic [11:0] STROBE_LAST  = 12'(STROBE_LEN - 1);
  localparam logic [11:0] SETTLE_LAST  = 12'(WAIT_SETTLE - 1);
  localparam logic [11:0] TIMEOUT_LAST = 12'(WAIT_TIMEOUT - 1);

  snd_state_t  state_reg, state_next;
  logic [11:0] cnt_reg, cnt_next;
  logic [7:0]  latch0_reg, latch0_next;
  logic [7:0]  latch1_reg, latch1_next;
  logic [7:0]  dout_reg, dout_next;
  logic        abort_reg, abort_next;
  logic        dtack_n_reg;
  logic        cs_reg;
  logic        irq_pend_reg;
  logic        tmo_reg;
  logic        wr_clr;
  logic        timeout_hit;
  logic        sel_rise;
  logic        sndirq_rise;

  batrider_edge_det #(.REG_OUT(1'b0)) u_sel_edge (
    .clk   (CLK96),
    .rst_n (RESET96_N),
    .d     (SEL),
    .rise  (sel_rise)
  );

  batrider_edge_det #(.REG_OUT(1'b1)) u_irq_edge (
    .clk   (CLK96),
    .rst_n (RESET96_N),
    .d     (SNDIRQ),
    .rise  (sndirq_rise)
  );

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    latch0_next = latch0_reg;
    latch1_next = latch1_reg;
    dout_next   = dout_reg;
    abort_next  = abort_reg;
    wr_clr      = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        abort_next = 1'b0;
        if (sel_rise) begin
          cnt_next   = '0;
          state_next = ST_ACK;
          // Accesses without the low data strobe only get DTACK.
          if (!LDSn) begin
            if (RWn) begin
              case (ADDR)
                REG_LATCH0: dout_next = SOUNDLATCH3;
                REG_LATCH1: dout_next = SOUNDLATCH4;
                REG_STROBE: dout_next = 8'hFF;
                default:    dout_next = {7'b0, irq_pend_reg};
              endcase
            end else begin
              case (ADDR)
                REG_LATCH0: latch0_next = M68K_DIN;
                REG_LATCH1: latch1_next = M68K_DIN;
                REG_STROBE: state_next  = ST_STROBE;
                default:    wr_clr      = 1'b1;
              endcase
            end
          end
        end
      end
      ST_STROBE: begin
        cnt_next = cnt_reg + 12'd1;
        if (!SEL) abort_next = 1'b1;
        // The CS pulse always runs to full length, even if the bus cycle was dropped.
        if (cnt_reg == STROBE_LAST) begin
          cnt_next   = '0;
          state_next = (abort_reg || !SEL) ? ST_IDLE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_next = cnt_reg + 12'd1;
        if (!SEL) begin
          state_next = ST_IDLE;
        end else if (cnt_reg == SETTLE_LAST) begin
          cnt_next   = '0;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!SEL) begin
          state_next = ST_IDLE;
        end else if (!WAIT) begin
          state_next = ST_ACK;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = ST_ACK;
        end else begin
          cnt_next = cnt_reg + 12'd1;
        end
      end
      ST_ACK: begin
        if (!SEL) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      latch0_reg   <= 8'h00;
      latch1_reg   <= 8'h00;
      dout_reg     <= 8'hFF;
      abort_reg    <= 1'b0;
      dtack_n_reg  <= 1'b1;
      cs_reg       <= 1'b0;
      irq_pend_reg <= 1'b0;
      tmo_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      latch0_reg   <= latch0_next;
      latch1_reg   <= latch1_next;
      dout_reg     <= dout_next;
      abort_reg    <= abort_next;
      dtack_n_reg  <= (state_next != ST_ACK);
      cs_reg       <= (state_next == ST_STROBE);
      // A new SNDIRQ edge beats a simultaneous acknowledge.
      irq_pend_reg <= sndirq_rise | (irq_pend_reg & ~(IACK | wr_clr));
      tmo_reg      <= tmo_reg | timeout_hit;
    end
  end

  assign M68K_DOUT   = dout_reg;
  assign DTACKn      = dtack_n_reg;
  assign SOUNDLATCH  = latch0_reg;
  assign SOUNDLATCH2 = latch1_reg;
  assign CS          = cs_reg;
  assign IRQn        = ~irq_pend_reg;

endmodule

// File: tb/tb_batrider_snd_mailbox.sv
// Bench for batrider_snd_mailbox: table of bus accesses plus hand-written
// strobe, timeout, abort, reset and interrupt sequences.
module tb_batrider_snd_mailbox;
  import batrider_snd_pkg::*;

  logic       CLK96 = 1'b0;
  logic       RESET96_N;
  logic       SEL, RWn, LDSn, WAIT, SNDIRQ, IACK;
  logic [1:0] ADDR;
  logic [7:0] M68K_DIN, SOUNDLATCH3, SOUNDLATCH4;
  logic [7:0] M68K_DOUT, SOUNDLATCH, SOUNDLATCH2;
  logic       DTACKn, CS, IRQn;

  batrider_snd_mailbox dut (
    .CLK96       (CLK96),
    .RESET96_N   (RESET96_N),
    .SEL         (SEL),
    .RWn         (RWn),
    .LDSn        (LDSn),
    .ADDR        (ADDR),
    .M68K_DIN    (M68K_DIN),
    .M68K_DOUT   (M68K_DOUT),
    .DTACKn      (DTACKn),
    .SOUNDLATCH  (SOUNDLATCH),
    .SOUNDLATCH2 (SOUNDLATCH2),
    .CS          (CS),
    .WAIT        (WAIT),
    .SOUNDLATCH3 (SOUNDLATCH3),
    .SOUNDLATCH4 (SOUNDLATCH4),
    .SNDIRQ      (SNDIRQ),
    .IACK        (IACK),
    .IRQn        (IRQn)
  );

  always #5 CLK96 = ~CLK96;

  int cyc = 0;
  always @(posedge CLK96) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] dout;
    logic       chk_dout;
    logic [7:0] l0;
    logic [7:0] l1;
    int         lat;   // negative: latency checked separately
    int         cs;
  } exp_t;

  typedef struct {
    logic       rwn;
    logic       ldsn;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] sl3;
    logic [7:0] sl4;
    exp_t       e;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];
  exp_t exp_q[$];

  int n_err = 0;
  int n_checks = 0;
  int lat, cs_cnt, ack_cyc, wait_fall_cyc, dt_low;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk_exp(input logic chk_dout, input logic [7:0] dout,
                                  input logic [7:0] l0, input logic [7:0] l1,
                                  input int lat_e, input int cs_e);
    exp_t e;
    e.dout = dout; e.chk_dout = chk_dout; e.l0 = l0; e.l1 = l1;
    e.lat = lat_e; e.cs = cs_e;
    return e;
  endfunction

  function automatic vec_t mk(input logic rwn, input logic ldsn, input logic [1:0] addr,
                              input logic [7:0] din, input logic [7:0] sl3, input logic [7:0] sl4,
                              input logic [7:0] dout, input logic [7:0] l0, input logic [7:0] l1);
    vec_t v;
    v.rwn = rwn; v.ldsn = ldsn; v.addr = addr; v.din = din; v.sl3 = sl3; v.sl4 = sl4;
    v.e = mk_exp(rwn & ~ldsn, dout, l0, l1, 1, 0);
    return v;
  endfunction

  // One full 68k bus cycle: expectation queued at drive time, checked when DTACK arrives.
  task automatic access(input logic rwn, input logic ldsn, input logic [1:0] addr,
                        input logic [7:0] din, input exp_t e);
    exp_t got;
    exp_q.push_back(e);
    @(negedge CLK96);
    SEL = 1'b1; RWn = rwn; LDSn = ldsn; ADDR = addr; M68K_DIN = din;
    lat = 0; cs_cnt = 0;
    do begin
      @(negedge CLK96);
      lat++;
      if (CS) cs_cnt++;
    end while (DTACKn && lat < 6000);
    ack_cyc = cyc;
    got = exp_q.pop_front();
    chk("dtack_seen", DTACKn, 1'b0);
    if (got.lat >= 0) chk("dtack_latency", lat, got.lat);
    chk("cs_cycles", cs_cnt, got.cs);
    if (got.chk_dout) chk("dout", M68K_DOUT, got.dout);
    chk("soundlatch", SOUNDLATCH, got.l0);
    chk("soundlatch2", SOUNDLATCH2, got.l1);
    $display("txn rw=%0d lds_n=%0d addr=%0d din=%02h dout=%02h lat=%0d cs=%0d sl=%02h sl2=%02h",
             rwn, ldsn, addr, din, M68K_DOUT, lat, cs_cnt, SOUNDLATCH, SOUNDLATCH2);
    SEL = 1'b0; LDSn = 1'b1; RWn = 1'b1;
    @(negedge CLK96);
    chk("dtack_release", DTACKn, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(1'b0, 1'b0, 2'd0, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h00);
    vecs[1] = mk(1'b0, 1'b0, 2'd1, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hA5);
    vecs[2] = mk(1'b1, 1'b0, 2'd0, 8'h00, 8'h3C, 8'h00, 8'h3C, 8'h5A, 8'hA5);
    vecs[3] = mk(1'b1, 1'b0, 2'd2, 8'h00, 8'h3C, 8'h00, 8'hFF, 8'h5A, 8'hA5);
    vecs[4] = mk(1'b1, 1'b0, 2'd1, 8'h00, 8'h3C, 8'hC3, 8'hC3, 8'h5A, 8'hA5);
    vecs[5] = mk(1'b1, 1'b0, 2'd3, 8'h00, 8'h3C, 8'hC3, 8'h00, 8'h5A, 8'hA5);
    vecs[6] = mk(1'b0, 1'b0, 2'd3, 8'hFF, 8'h3C, 8'hC3, 8'h00, 8'h5A, 8'hA5);
    vecs[7] = mk(1'b0, 1'b0, 2'd0, 8'h11, 8'h3C, 8'hC3, 8'h00, 8'h11, 8'hA5);
    vecs[8] = mk(1'b1, 1'b0, 2'd0, 8'h00, 8'hE7, 8'hC3, 8'hE7, 8'h11, 8'hA5);
    vecs[9] = mk(1'b0, 1'b1, 2'd1, 8'h99, 8'hE7, 8'hC3, 8'h00, 8'h11, 8'hA5);

    RESET96_N = 1'b0; SEL = 1'b0; RWn = 1'b1; LDSn = 1'b1; ADDR = 2'd0;
    M68K_DIN = 8'h00; WAIT = 1'b0; SNDIRQ = 1'b0; IACK = 1'b0;
    SOUNDLATCH3 = 8'h00; SOUNDLATCH4 = 8'h00;
    repeat (3) @(negedge CLK96);
    chk("rst_dtack", DTACKn, 1'b1);
    chk("rst_cs", CS, 1'b0);
    chk("rst_irqn", IRQn, 1'b1);
    chk("rst_dout", M68K_DOUT, 8'hFF);
    chk("rst_latch0", SOUNDLATCH, 8'h00);
    chk("rst_latch1", SOUNDLATCH2, 8'h00);
    RESET96_N = 1'b1;
    @(negedge CLK96);

    for (int i = 0; i < NV; i++) begin
      SOUNDLATCH3 = vecs[i].sl3;
      SOUNDLATCH4 = vecs[i].sl4;
      access(vecs[i].rwn, vecs[i].ldsn, vecs[i].addr, vecs[i].din, vecs[i].e);
    end

    // Asynchronous reset in the middle of a CS pulse
    @(negedge CLK96);
    SEL = 1'b1; RWn = 1'b0; LDSn = 1'b0; ADDR = 2'd2;
    repeat (2) @(negedge CLK96);
    chk("mid_strobe_cs", CS, 1'b1);
    RESET96_N = 1'b0;
    #1;
    chk("arst_cs", CS, 1'b0);
    chk("arst_dtack", DTACKn, 1'b1);
    chk("arst_latch0", SOUNDLATCH, 8'h00);
    chk("arst_latch1", SOUNDLATCH2, 8'h00);
    chk("arst_dout", M68K_DOUT, 8'hFF);
    SEL = 1'b0; LDSn = 1'b1; RWn = 1'b1;
    repeat (2) @(negedge CLK96);
    RESET96_N = 1'b1;
    @(negedge CLK96);
    chk("arst_state_idle", dut.state_reg, ST_IDLE);

    // Interrupt path
    @(negedge CLK96);
    SNDIRQ = 1'b1;
    @(negedge CLK96);
    chk("irq_after_1", IRQn, 1'b1);
    @(negedge CLK96);
    chk("irq_after_2", IRQn, 1'b0);
    SNDIRQ = 1'b0;
    repeat (2) @(negedge CLK96);
    SNDIRQ = 1'b1;
    @(negedge CLK96);
    IACK = 1'b1;
    @(negedge CLK96);
    IACK = 1'b0;
    chk("irq_set_wins", IRQn, 1'b0);
    access(1'b1, 1'b0, 2'd3, 8'h00, mk_exp(1'b1, 8'h01, 8'h00, 8'h00, 1, 0));
    access(1'b0, 1'b0, 2'd3, 8'h00, mk_exp(1'b0, 8'h00, 8'h00, 8'h00, 1, 0));
    chk("irq_wr_clear", IRQn, 1'b1);
    access(1'b1, 1'b0, 2'd3, 8'h00, mk_exp(1'b1, 8'h00, 8'h00, 8'h00, 1, 0));
    SNDIRQ = 1'b0;
    repeat (2) @(negedge CLK96);
    SNDIRQ = 1'b1;
    repeat (3) @(negedge CLK96);
    chk("irq_reset", IRQn, 1'b0);
    IACK = 1'b1;
    @(negedge CLK96);
    IACK = 1'b0;
    chk("irq_iack_clear", IRQn, 1'b1);
    @(negedge CLK96);
    chk("irq_level_no_reset", IRQn, 1'b1);

    // Strobe with WAIT raised one cycle after CS and released 50 cycles later
    wait_fall_cyc = 0;
    fork
      access(1'b0, 1'b0, 2'd2, 8'h77, mk_exp(1'b0, 8'h00, 8'h00, 8'h00, -1, 4));
      begin
        for (int i = 0; i < 20 && !CS; i++) @(negedge CLK96);
        chk("wait_cs_rise", CS, 1'b1);
        @(negedge CLK96);
        WAIT = 1'b1;
        repeat (50) @(negedge CLK96);
        WAIT = 1'b0;
        wait_fall_cyc = cyc;
      end
    join
    chk("wait_fall_to_dtack", ack_cyc - wait_fall_cyc, 1);
    chk("strobe_min_latency", (lat >= 7), 1'b1);
    chk("tmo_clear", dut.tmo_reg, 1'b0);

    // WAIT stuck high: DTACK after the full timeout
    WAIT = 1'b1;
    access(1'b0, 1'b0, 2'd2, 8'h00, mk_exp(1'b0, 8'h00, 8'h00, 8'h00, 4 + 2 + 4096 + 1, 4));
    chk("tmo_set", dut.tmo_reg, 1'b1);
    WAIT = 1'b0;
    SOUNDLATCH3 = 8'h3C;
    access(1'b1, 1'b0, 2'd0, 8'h00, mk_exp(1'b1, 8'h3C, 8'h00, 8'h00, 1, 0));

    // SEL dropped during the strobe: CS keeps its full length, no DTACK
    @(negedge CLK96);
    SEL = 1'b1; RWn = 1'b0; LDSn = 1'b0; ADDR = 2'd2;
    cs_cnt = 0; dt_low = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK96);
      if (CS) cs_cnt++;
      if (!DTACKn) dt_low++;
      if (i == 1) begin
        SEL = 1'b0; LDSn = 1'b1; RWn = 1'b1;
      end
    end
    chk("abort_cs_len", cs_cnt, 4);
    chk("abort_no_dtack", dt_low, 0);
    chk("abort_state_idle", dut.state_reg, ST_IDLE);
    access(1'b1, 1'b0, 2'd2, 8'h00, mk_exp(1'b1, 8'hFF, 8'h00, 8'h00, 1, 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
